// File: rtl/ppu_vout_align_pkg.sv
// rtl/ppu_vout_align_pkg.sv - shared video parameters for the output aligner
package ppu_vout_align_pkg;

  // Bit positions inside the {nVSYNC,nCLAMP,nHSYNC,nCSYNC} sync bundle
  localparam int SYNC_NCSYNC = 0;
  localparam int SYNC_NHSYNC = 1;
  localparam int SYNC_NCLAMP = 2;
  localparam int SYNC_NVSYNC = 3;

  // cfg_filter code that defers the filter choice to the line-multiplier mode
  localparam logic [2:0] FILTER_AUTO = 3'd0;

  // Largest supported blanking length and the counter width that holds it
  localparam int HOLD_CYC_MAX = 255;
  localparam int HOLD_CNT_W   = 8;

  typedef enum logic {
    HOLD_ST_IDLE  = 1'b0,
    HOLD_ST_BLANK = 1'b1
  } hold_state_e;

  // Filter[1:2] as a 2-bit code: bit 1 is Filter[1], bit 0 is Filter[2]
  function automatic logic [1:0] filter_code(input logic [2:0] cfg_filter,
                                             input logic [1:0] linemult);
    if (cfg_filter == FILTER_AUTO) return linemult;
    return cfg_filter[1:0] - 2'd1;
  endfunction

endpackage

// File: rtl/ppu_vdelay_line.sv
// rtl/ppu_vdelay_line.sv - selectable-depth pixel delay line with synchronous clear
module ppu_vdelay_line #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       sel_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] taps_q [DEPTH];
  logic [WIDTH-1:0] taps_d [DEPTH];

  // Shift history one tap per pixel, or wipe it while the output is blanked
  always_comb begin
    for (int k = 0; k < DEPTH; k++) taps_d[k] = '0;
    if (!clear_i) begin
      taps_d[0] = din_i;
      for (int k = 1; k < DEPTH; k++) taps_d[k] = taps_q[k-1];
    end
  end

  // Tap storage; reset discards any history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  // Select 0 bypasses the taps; select n reads the pixel from n cycles ago
  always_comb begin
    dout_o = din_i;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel_i == 3'(k + 1)) dout_o = taps_q[k];
    end
  end

endmodule

// File: rtl/ppu_vout_align.sv
// rtl/ppu_vout_align.sv - aligns colour to sync, muxes sync/filter pins, blanks on source switch
module ppu_vout_align
  import ppu_vout_align_pkg::*;
#(
  parameter int COLOR_W  = 8,
  parameter int MAX_DLY  = 3,
  parameter int HOLD_CYC = 255
) (
  input  logic                   VCLK,
  input  logic                   VRST,
  input  logic [3*COLOR_W-1:0]   vdata_i,
  input  logic [3:0]             sync_i,
  input  logic                   src_sel,
  input  logic [2:0]             cfg_dly,
  input  logic                   cfg_nEN_RGsB,
  input  logic                   cfg_nEN_YPbPr,
  input  logic [2:0]             cfg_filter,
  input  logic [1:0]             cfg_linemult,
  input  logic                   use_vga_sync,
  output logic [3*COLOR_W-1:0]   vdata_o,
  output logic [1:0]             nCSYNC_o,
  output logic                   nVSYNC_or_F2,
  output logic                   nHSYNC_or_F1,
  output logic                   out_valid
);

  localparam int                    DW        = 3 * COLOR_W;
  localparam logic [2:0]            DLY_MAX   = 3'(MAX_DLY);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYC);

  hold_state_e           state_q, state_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  src_q;
  logic                  src_chg;
  logic                  blank;
  logic [2:0]            dly_sel;
  logic [DW-1:0]         tap_pix;
  logic [DW-1:0]         vdata_q, vdata_d;
  logic                  csync_q, hsync_q, vsync_q;
  logic                  soc_en_q, vga_q;
  logic [1:0]            filter_q, filter_d;
  logic                  unused_clamp;

  assign unused_clamp = sync_i[SYNC_NCLAMP];
  assign src_chg      = src_sel ^ src_q;
  assign blank        = (state_q == HOLD_ST_BLANK);
  assign dly_sel      = (cfg_dly > DLY_MAX) ? DLY_MAX : cfg_dly;
  assign vdata_d      = blank ? '0 : tap_pix;
  assign filter_d     = filter_code(cfg_filter, cfg_linemult);

  ppu_vdelay_line #(
    .WIDTH (DW),
    .DEPTH (MAX_DLY)
  ) u_dly (
    .clk_i   (VCLK),
    .rst_i   (VRST),
    .sel_i   (dly_sel),
    .clear_i (blank),
    .din_i   (vdata_i),
    .dout_o  (tap_pix)
  );

  // Hold FSM state register: reset starts a full blanking interval
  always_ff @(posedge VCLK or posedge VRST) begin
    if (VRST) begin
      state_q <= HOLD_ST_BLANK;
      cnt_q   <= HOLD_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold FSM next state: a source switch reloads, otherwise count down to idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (src_chg) begin
      state_d = HOLD_ST_BLANK;
      cnt_d   = HOLD_LOAD;
    end else if (state_q == HOLD_ST_BLANK) begin
      cnt_d = cnt_q - HOLD_CNT_W'(1);
      if (cnt_q == HOLD_CNT_W'(1)) state_d = HOLD_ST_IDLE;
    end
  end

  // One-cycle output stage for pixels, syncs and pin configuration
  always_ff @(posedge VCLK or posedge VRST) begin
    if (VRST) begin
      src_q    <= 1'b0;
      vdata_q  <= '0;
      csync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      soc_en_q <= 1'b0;
      vga_q    <= 1'b0;
      filter_q <= '0;
    end else begin
      src_q    <= src_sel;
      vdata_q  <= vdata_d;
      csync_q  <= sync_i[SYNC_NCSYNC];
      hsync_q  <= sync_i[SYNC_NHSYNC];
      vsync_q  <= sync_i[SYNC_NVSYNC];
      soc_en_q <= ~(cfg_nEN_RGsB & cfg_nEN_YPbPr);
      vga_q    <= use_vga_sync;
      filter_q <= filter_d;
    end
  end

  // Hold FSM outputs: everything is forced low while blanking
  always_comb begin
    out_valid    = (state_q == HOLD_ST_IDLE);
    vdata_o      = '0;
    nCSYNC_o     = 2'b00;
    nVSYNC_or_F2 = 1'b0;
    nHSYNC_or_F1 = 1'b0;
    if (out_valid) begin
      vdata_o  = vdata_q;
      nCSYNC_o = {csync_q, csync_q & soc_en_q};
      if (vga_q) begin
        nVSYNC_or_F2 = vsync_q;
        nHSYNC_or_F1 = hsync_q;
      end else begin
        nVSYNC_or_F2 = filter_q[0] & ~filter_q[1];
        nHSYNC_or_F1 = filter_q[1] & ~filter_q[0];
      end
    end
  end

endmodule

// File: tb/tb_ppu_vout_align.sv
// tb/tb_ppu_vout_align.sv - randomized scoreboard bench for ppu_vout_align
module tb_ppu_vout_align;

  localparam int CW = 8;
  localparam int MD = 3;
  localparam int HC = 255;
  localparam int DW = 3 * CW;

  logic          VCLK = 1'b0;
  logic          VRST = 1'b1;
  logic [DW-1:0] vdata_i = '0;
  logic [3:0]    sync_i = 4'hF;
  logic          src_sel = 1'b0;
  logic [2:0]    cfg_dly = 3'd0;
  logic          cfg_nEN_RGsB = 1'b0;
  logic          cfg_nEN_YPbPr = 1'b0;
  logic [2:0]    cfg_filter = 3'd0;
  logic [1:0]    cfg_linemult = 2'd0;
  logic          use_vga_sync = 1'b1;
  logic [DW-1:0] vdata_o;
  logic [1:0]    nCSYNC_o;
  logic          nVSYNC_or_F2;
  logic          nHSYNC_or_F1;
  logic          out_valid;

  typedef struct packed {
    logic [DW-1:0] vd;
    logic [1:0]    nc;
    logic          nv;
    logic          nh;
    logic          ov;
  } obs_t;

  obs_t          exp_q[$];
  obs_t          mon_e;
  obs_t          obs_now;
  int            vectors = 0;
  int            miscompares = 0;
  int            edge_n = 0;
  int            blank_until = 0;
  logic          src_prev = 1'b0;
  logic          valid_before = 1'b0;
  logic [DW-1:0] hist [MD];

  assign obs_now = {vdata_o, nCSYNC_o, nVSYNC_or_F2, nHSYNC_or_F1, out_valid};

  ppu_vout_align #(.COLOR_W(CW), .MAX_DLY(MD), .HOLD_CYC(HC)) dut (
    .VCLK          (VCLK),
    .VRST          (VRST),
    .vdata_i       (vdata_i),
    .sync_i        (sync_i),
    .src_sel       (src_sel),
    .cfg_dly       (cfg_dly),
    .cfg_nEN_RGsB  (cfg_nEN_RGsB),
    .cfg_nEN_YPbPr (cfg_nEN_YPbPr),
    .cfg_filter    (cfg_filter),
    .cfg_linemult  (cfg_linemult),
    .use_vga_sync  (use_vga_sync),
    .vdata_o       (vdata_o),
    .nCSYNC_o      (nCSYNC_o),
    .nVSYNC_or_F2  (nVSYNC_or_F2),
    .nHSYNC_or_F1  (nHSYNC_or_F1),
    .out_valid     (out_valid)
  );

  always #5 VCLK = ~VCLK;

  // Reference: what the outputs must be right after the coming rising edge
  task automatic model_edge();
    obs_t          e;
    int            d;
    logic [DW-1:0] pick;
    logic          clr;
    logic          vout;
    logic [1:0]    fcode;
    edge_n++;
    e = '0;
    if (VRST) begin
      for (int k = 0; k < MD; k++) hist[k] = '0;
      src_prev     = 1'b0;
      valid_before = 1'b0;
      blank_until  = edge_n + HC;
    end else begin
      clr = !valid_before;
      if (src_sel != src_prev) blank_until = edge_n + HC;
      src_prev = src_sel;
      vout = (edge_n >= blank_until);
      d = (int'(cfg_dly) > MD) ? MD : int'(cfg_dly);
      pick = (d == 0) ? vdata_i : hist[d-1];
      if (clr) begin
        for (int k = 0; k < MD; k++) hist[k] = '0;
      end else begin
        for (int k = MD - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = vdata_i;
      end
      fcode = (cfg_filter == 3'd0) ? cfg_linemult : 2'(cfg_filter[1:0] - 2'd1);
      if (vout) begin
        e.ov = 1'b1;
        e.vd = clr ? '0 : pick;
        e.nc = {sync_i[0], (cfg_nEN_RGsB && cfg_nEN_YPbPr) ? 1'b0 : sync_i[0]};
        e.nv = use_vga_sync ? sync_i[3] : (fcode == 2'b01);
        e.nh = use_vga_sync ? sync_i[1] : (fcode == 2'b10);
      end
      valid_before = vout;
    end
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: drive, predict, then wait for the next falling edge
  task automatic step(input logic rst, input logic [DW-1:0] pix, input logic [3:0] sy);
    VRST    = rst;
    vdata_i = pix;
    sync_i  = sy;
    if (rst) begin
      #1;
      vectors++;
      if (obs_now !== '0) begin
        miscompares++;
        $display("FAIL async_reset: outputs=%h required=0", obs_now);
      end
    end
    model_edge();
    @(negedge VCLK);
  endtask

  task automatic rstep();
    logic [31:0] r;
    r = $urandom();
    step(1'b0, r[DW-1:0], 4'($urandom_range(0, 15)));
  endtask

  task automatic rand_cfg();
    cfg_dly       = 3'($urandom_range(0, 7));
    cfg_nEN_RGsB  = 1'($urandom_range(0, 1));
    cfg_nEN_YPbPr = 1'($urandom_range(0, 1));
    cfg_filter    = 3'($urandom_range(0, 7));
    cfg_linemult  = 2'($urandom_range(0, 3));
    use_vga_sync  = 1'($urandom_range(0, 1));
  endtask

  // Monitor: compare every presented output against the oldest prediction
  initial begin
    forever begin
      @(posedge VCLK);
      #2;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        vectors++;
        if (obs_now !== mon_e) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got vd=%h nc=%b nv=%b nh=%b ov=%b required vd=%h nc=%b nv=%b nh=%b ov=%b",
                   $time, obs_now.vd, obs_now.nc, obs_now.nv, obs_now.nh, obs_now.ov,
                   mon_e.vd, mon_e.nc, mon_e.nv, mon_e.nh, mon_e.ov);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < MD; k++) hist[k] = '0;
    @(negedge VCLK);
    repeat (3) step(1'b1, '0, 4'hF);

    // power-up blanking with random traffic and delay settings
    for (int i = 0; i < HC + 10; i++) begin
      cfg_dly = 3'($urandom_range(0, 7));
      rstep();
    end

    // single red pixel and csync pulse, delay 2
    use_vga_sync = 1'b1;
    cfg_dly = 3'd2;
    step(1'b0, '0, 4'hF);
    step(1'b0, 24'hFF0000, 4'hE);
    repeat (6) step(1'b0, '0, 4'hF);

    // delay request above MAX_DLY saturates
    cfg_dly = 3'd7;
    repeat (20) rstep();

    // filter select pins
    use_vga_sync = 1'b0;
    cfg_filter = 3'd0;
    cfg_linemult = 2'b01;
    repeat (4) rstep();
    cfg_filter = 3'd3;
    repeat (4) rstep();
    for (int i = 0; i < 16; i++) begin
      cfg_filter = 3'($urandom_range(0, 7));
      cfg_linemult = 2'($urandom_range(0, 3));
      rstep();
    end

    // sync-on-green disabled by both enables high
    use_vga_sync = 1'b1;
    cfg_nEN_RGsB = 1'b1;
    cfg_nEN_YPbPr = 1'b1;
    repeat (10) rstep();

    // fully random configuration, steady source
    for (int i = 0; i < 300; i++) begin
      rand_cfg();
      rstep();
    end

    // source switch, second switch 100 cycles in
    src_sel = 1'b1;
    repeat (100) rstep();
    src_sel = 1'b0;
    for (int i = 0; i < HC + 50; i++) begin
      rand_cfg();
      rstep();
    end

    // reset mid-frame, then recovery
    cfg_dly = 3'd3;
    repeat (20) rstep();
    repeat (3) step(1'b1, 24'h123456, 4'h5);
    for (int i = 0; i < HC + 20; i++) begin
      rand_cfg();
      rstep();
    end

    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
